// File: rtl/spi_cmd_master.sv
// SPI command master (mode 0). Sends one {rnw, addr, wdata} frame, MSB first, to the slave
// picked by cs_sel. On read frames it also returns the last DATA_W bits sampled on miso.
// A transfer starts on a 0->1 edge of the start level from the register bank.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 request level; only its rising edge starts a transfer
//   rnw, cs_sel           frame type (1 = read) and slave index
//   addr, wdata           frame address and frame write data
//   busy, done            transfer in progress / one-cycle end-of-transfer pulse
//   rdata, rdata_valid    last captured read data / pulse with done on read frames
//   sel_err               pulse when a start edge names a slave index >= NUM_CS
//   start_ignored         pulse when a start edge arrives while busy
//   sclk, cs_n, mosi, miso  SPI bus; sclk idles low, cs_n active low
module spi_cmd_master #(
  parameter int unsigned NUM_CS  = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rnw,
  input  logic [2:0]        cs_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              sel_err,
  output logic              start_ignored,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam int unsigned EDGE_W  = $clog2(2 * FRAME_W);
  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EdgeLast = EDGE_W'(2 * FRAME_W - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_cmd_master: CLK_DIV must be at least 2");
  end
  if (NUM_CS < 1 || NUM_CS > 8) begin : g_bad_num_cs
    $error("spi_cmd_master: NUM_CS must be in 1..8");
  end

  typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StGap} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;     // sclk edges issued so far in SHIFT
  logic                start_q;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                rnw_q, rnw_d;
  logic                sclk_q, sclk_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                sel_err_q, sel_err_d;
  logic                ign_q, ign_d;
  logic                start_edge;
  logic                sel_ok;

  assign start_edge = start & ~start_q;
  assign sel_ok     = 32'(cs_sel) < NUM_CS;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    edge_d        = edge_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    rnw_d         = rnw_q;
    sclk_d        = sclk_q;
    cs_n_d        = cs_n_q;
    rdata_d       = rdata_q;
    done_d        = 1'b0;
    rdata_valid_d = 1'b0;
    sel_err_d     = 1'b0;
    ign_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          if (sel_ok) begin
            state_d = StLead;
            cnt_d   = '0;
            edge_d  = '0;
            tx_d    = {rnw, addr, wdata};
            rnw_d   = rnw;
            rx_d    = '0;
            for (int i = 0; i < NUM_CS; i++) begin
              cs_n_d[i] = (cs_sel != 3'(i));
            end
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      StLead: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (!sclk_q) begin
            // Rising edge: capture miso; the shift register keeps the last DATA_W bits.
            rx_d = {rx_q[DATA_W-2:0], miso};
          end else if (edge_q == EdgeLast) begin
            // Final falling edge: mosi stays on the last bit through TRAIL.
            state_d = StTrail;
          end else begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      StTrail: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          cs_n_d  = '1;
          tx_d    = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
          if (rnw_q) begin
            rdata_d       = rx_q;
            rdata_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && start_edge) begin
      ign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      edge_q        <= '0;
      start_q       <= 1'b0;
      tx_q          <= '0;
      rx_q          <= '0;
      rnw_q         <= 1'b0;
      sclk_q        <= 1'b0;
      cs_n_q        <= '1;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
      ign_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      edge_q        <= edge_d;
      start_q       <= start;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      rnw_q         <= rnw_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      sel_err_q     <= sel_err_d;
      ign_q         <= ign_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign sel_err       = sel_err_q;
  assign start_ignored = ign_q;
  assign sclk          = sclk_q;
  assign cs_n          = cs_n_q;
  assign mosi          = tx_q[FRAME_W-1];

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
Parametrised SPI command master that generalises the fixed single-slave Artix SPI write path. It serialises a {rnw, address, data} frame to one of NUM_CS slaves and captures read-back data on read frames. It sits behind the PS-side AXI register bank: software writes the data, address and select fields, then pulses a start register bit (write 1, then 0). Status and read data return through the same register bank.

Parameters:
NUM_CS, 2, number of slave chip selects (1..8)
ADDR_W, 8, address field width in bits
DATA_W, 16, data field width in bits
CLK_DIV, 4, sclk half-period in clk cycles; elaboration error if < 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level from register; a 0->1 transition requests a transfer
rnw  in  1  1 = read frame, 0 = write frame
cs_sel  in  3  slave index
addr  in  ADDR_W  frame address
wdata  in  DATA_W  frame write data
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer
rdata  out  DATA_W  last captured read data
rdata_valid  out  1  one-cycle pulse with done on read frames
sel_err  out  1  one-cycle pulse when start is rejected because cs_sel >= NUM_CS
start_ignored  out  1  one-cycle pulse when a start edge arrives while busy
sclk  out  1  SPI clock, mode 0 (idle low)
cs_n  out  NUM_CS  active-low selects
mosi  out  1  serial out, MSB first
miso  in  1  serial in

Behaviour:
- Reset values: busy=0, done=0, rdata=0, rdata_valid=0, sel_err=0, start_ignored=0, sclk=0, cs_n=all 1, mosi=0, FSM=IDLE.
- start edge detect: registered start_d; edge = start & ~start_d. A held-high start never retriggers.
- Frame: FRAME_W = 1+ADDR_W+DATA_W bits = {rnw, addr, wdata}, MSB first. Inputs are latched on the edge cycle.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP.
  - IDLE: on edge with cs_sel < NUM_CS, go to LEAD on the next clk. busy=1, cs_n[cs_sel]=0, mosi=frame MSB. On edge with cs_sel >= NUM_CS, pulse sel_err and stay in IDLE.
  - LEAD: hold for CLK_DIV cycles with sclk=0, then go to SHIFT.
  - SHIFT: sclk toggles every CLK_DIV cycles, starting with a rise.
    - On each rising edge, sample miso into the capture shift register.
    - On each falling edge except the last, shift mosi to the next bit.
    - Exit after FRAME_W rising and FRAME_W falling edges (2*CLK_DIV*FRAME_W cycles), with sclk=0.
  - TRAIL: hold for CLK_DIV cycles with cs still low and mosi held, then deassert all cs_n.
  - GAP: hold for CLK_DIV cycles with cs_n high, then go to IDLE.
- On the first IDLE cycle: busy=0 and done=1 for one cycle. If the frame was a read, rdata = last DATA_W sampled miso bits (first sampled bit is MSB) and rdata_valid=1 on the same cycle. rdata holds otherwise; write frames leave rdata unchanged.
- Busy duration: exactly CLK_DIV*(2*FRAME_W+3) cycles.
- Start edge while busy: ignored. start_ignored pulses; the frame in flight is unaffected.
- Start edge on the same cycle as done: accepted as a new transfer; LEAD begins next cycle.
- Reset mid-transfer: on the next clk all outputs take their reset values (cs_n high, sclk 0) and the partial capture is discarded.
- Only one cs_n bit is ever low at a time.

Test Plan:
- Write, defaults (FRAME_W=25): cs_sel=0, addr=0x03, wdata=0x0001, rnw=0, pulse start. Required response:
  - mosi stream = 0,0x03,0x0001 sampled on 25 sclk rises.
  - cs_n=2'b10; busy high for 212 cycles; one done pulse; rdata_valid stays 0.
- Read: cs_sel=1, addr=0xA5, rnw=1, slave model drives 0xBEEF on miso during the data field. Required response: cs_n=2'b01; rdata=0xBEEF with rdata_valid and done on the same cycle.
- Bad select: cs_sel=2, pulse start. Required response: sel_err pulse; cs_n stays 2'b11; busy stays 0; no sclk activity.
- Start edge at busy cycle 50. Required response: start_ignored pulse; frame completes unchanged in 212 cycles; only one done pulse.
- Assert reset at busy cycle 100. Required response: next cycle cs_n=2'b11, sclk=0, busy=0, no done; a following start performs a clean full frame.
- start held high for 1000 cycles. Required response: exactly one transfer. Plus a CLK_DIV=2 rebuild: busy = 106 cycles and sclk period = 4 clk.
